// File: rtl/stall_sequencer_if.sv
// Core-facing bundle for stall_sequencer: the core presents next_pc and
// jbr_taken, the sequencer returns stall, end-of-program status and CPI counters.
interface stall_sequencer_if #(
  parameter int CNT_W = 32
);
  // Handshake: there is no valid/ready pair. next_pc and jbr_taken are sampled
  // on every rising clk edge, and every output is a register that reflects the
  // decision made at the previous edge. The core obeys stall in the same cycle
  // that stall is high.
  logic [31:0]      next_pc;
  logic             jbr_taken;
  logic             stall;
  logic             halted;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output next_pc, jbr_taken,
    input  stall, halted, done, cycle_cnt, stall_cnt, state_dbg
  );

  modport slave (
    input  next_pc, jbr_taken,
    output stall, halted, done, cycle_cnt, stall_cnt, state_dbg
  );
endinterface

// File: rtl/stall_sequencer.sv
// Stall and end-of-program controller for the pipelined MIPS core.
// Generates the core stall (off / fixed burst / LFSR random with a cap on
// consecutive stalls), spots the halt PC, lets the pipeline drain, then raises
// a sticky done. Also counts run cycles and stall cycles for CPI measurement.
module stall_sequencer #(
  parameter int          MODE         = 1,
  parameter int          STALL_CYCLES = 4,
  parameter int          RAND_THRESH  = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] HALT_PC      = 32'h8008_8008,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          CNT_W        = 32
) (
  input logic              clk,
  input logic              rst,
  stall_sequencer_if.slave bus
);

  // Reject configurations the stall logic cannot honour.
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $fatal(1, "stall_sequencer: LFSR_SEED must be nonzero");
  end
  if (STALL_CYCLES == 0 && MODE != 0) begin : g_bad_cycles
    $fatal(1, "stall_sequencer: STALL_CYCLES must be nonzero when stalling");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       CAP     = 4'(STALL_CYCLES);
  localparam logic [4:0]       THRESH  = 5'(RAND_THRESH);
  localparam logic [8:0]       DRAIN_N = 9'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             stall_q;
  logic             halted_q;
  logic             done_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [3:0]       cnt;
  logic [15:0]      lfsr;
  logic [7:0]       drain_cnt;

  logic             lfsr_fb;
  logic             rand_hit;
  logic             run_stall;
  logic             halt_hit;
  logic             drain_last;

  // Next-cycle decisions: stall request while running, halt detect, drain end.
  always_comb begin
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    rand_hit   = {1'b0, lfsr[3:0]} < THRESH;
    halt_hit   = (bus.next_pc == HALT_PC);
    // Adding one before the compare makes DRAIN_CYCLES=0 finish on the first
    // drain edge, and a count of N finish on the Nth drain edge.
    drain_last = (({1'b0, drain_cnt} + 9'd1) >= DRAIN_N);
    run_stall  = 1'b0;
    case (MODE)
      1:       run_stall = !bus.jbr_taken && (cnt != CAP);
      2:       run_stall = rand_hit && (cnt < CAP) && !bus.jbr_taken;
      default: run_stall = 1'b0;
    endcase
  end

  // RUN -> DRAIN -> DONE sequencer with all outputs registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      stall_q     <= 1'b0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
      cycle_q     <= '0;
      stall_cnt_q <= '0;
      cnt         <= 4'd0;
      lfsr        <= LFSR_SEED;
      drain_cnt   <= 8'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cycle_q != CNT_MAX) cycle_q <= cycle_q + CNT_W'(1);
          if (stall_q && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
          lfsr <= {lfsr[14:0], lfsr_fb};
          if (halt_hit) begin
            // Halt beats every stall rule so the drain starts immediately.
            state     <= ST_DRAIN;
            halted_q  <= 1'b1;
            stall_q   <= 1'b0;
            cnt       <= 4'd0;
            drain_cnt <= 8'd0;
          end else begin
            stall_q <= run_stall;
            cnt     <= run_stall ? cnt + 4'd1 : 4'd0;
          end
        end
        ST_DRAIN: begin
          if (cycle_q != CNT_MAX) cycle_q <= cycle_q + CNT_W'(1);
          if (stall_q && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
          stall_q   <= 1'b0;
          drain_cnt <= drain_cnt + 8'd1;
          if (drain_last) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          // DONE: everything frozen until reset.
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall     = stall_q;
  assign bus.halted    = halted_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.state_dbg = state;

endmodule
